// File: rtl/mvu_pkg.sv
// mvu_pkg: shared widths, CSR map and sequencer types for the
// MVU CSR APB path.
package mvu_pkg;

   localparam int NMVU           = 8;
   localparam int MVUW           = $clog2(NMVU);
   localparam int APB_ADDR_WIDTH = MVUW + 12;
   localparam int APB_DATA_WIDTH = 32;
   localparam int APB_STRB_WIDTH = APB_DATA_WIDTH / 8;
   localparam int TIMEOUT_DFLT   = 256;

   typedef logic [APB_ADDR_WIDTH-1:0] apb_addr_t;
   typedef logic [APB_DATA_WIDTH-1:0] apb_data_t;
   typedef logic [APB_STRB_WIDTH-1:0] apb_strb_t;
   typedef logic [MVUW-1:0]           mvu_sel_t;
   typedef logic [11:0]               mvu_csr_t;

   localparam mvu_csr_t CSR_MVUCOMMAND = 12'hf55;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS
   } seq_state_t;

   function automatic logic is_command(input mvu_csr_t csr);
      return csr == CSR_MVUCOMMAND;
   endfunction

endpackage

// File: rtl/mvu_busy_tracker.sv
// mvu_busy_tracker: per-MVU job-in-flight flags.
// A set and a clear on the same MVU in one cycle leaves the flag set.
module mvu_busy_tracker
   import mvu_pkg::*;
(
   input  logic            clk,
   input  logic            rst_n,
   input  logic [NMVU-1:0] i_set,
   input  logic [NMVU-1:0] i_clr,
   output logic [NMVU-1:0] o_busy
);

   logic [NMVU-1:0] r_busy;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= '0;
      end else begin
         r_busy <= (r_busy & ~i_clr) | i_set;
      end
   end

   assign o_busy = r_busy;

endmodule

// File: rtl/mvu_csr_sequencer.sv
// mvu_csr_sequencer: CSR-write descriptors to APB writes,
// gated by per-MVU busy flags.
module mvu_csr_sequencer
  import mvu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_DFLT
)
(
  input  logic            clk,
  input  logic            rst_n,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  mvu_sel_t        cmd_mvu,
  input  mvu_csr_t        cmd_csr,
  input  apb_data_t       cmd_data,
  output apb_addr_t       paddr,
  output logic            psel,
  output logic            penable,
  output logic            pwrite,
  output apb_data_t       pwdata,
  output apb_strb_t       pstrb,
  input  logic            pready,
  input  logic            pslverr,
  input  logic [NMVU-1:0] mvu_done,
  output logic [NMVU-1:0] mvu_busy,
  output logic            idle,
  output logic            err,
  output mvu_sel_t        err_mvu,
  input  logic            err_clr
);

  seq_state_t r_state;
  apb_addr_t  r_paddr;
  apb_data_t  r_pwdata;
  apb_strb_t  r_pstrb;
  mvu_sel_t   r_tgt;
  mvu_sel_t   r_err_mvu;
  logic       r_is_cmd;
  logic       r_psel;
  logic       r_penable;
  logic       r_pwrite;
  logic       r_err;

  logic [NMVU-1:0] w_busy;
  logic [NMVU-1:0] w_set;
  logic            w_accept;
  logic            w_done;
  logic            w_timeout;
  logic            w_fail;
  logic            w_set_en;

  assign w_accept = rst_n
                  & (r_state == IDLE)
                  & cmd_valid
                  & ~w_busy[cmd_mvu];
  assign w_done   = (r_state == ACCESS) & pready;
  assign w_fail   = (w_done & pslverr)
                  | w_timeout;
  assign w_set_en = w_done & ~pslverr
                  & r_is_cmd;
  assign w_set    = w_set_en
                  ? (NMVU'(1) << r_tgt)
                  : '0;

`ifdef MVU_CSR_SEQ_TIMEOUT_EN
  localparam int CW =
    $clog2(TIMEOUT_CYCLES) + 1;

  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (r_state == ACCESS
                 && !pready) begin
      r_cnt <= r_cnt + CW'(1);
    end
  end

  assign w_timeout = (r_state == ACCESS)
                   & ~pready
                   & (r_cnt ==
                      CW'(TIMEOUT_CYCLES - 1));
`else
  assign w_timeout = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_paddr   <= '0;
      r_pwdata  <= '0;
      r_pstrb   <= '0;
      r_tgt     <= '0;
      r_is_cmd  <= 1'b0;
      r_psel    <= 1'b0;
      r_penable <= 1'b0;
      r_pwrite  <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_paddr  <= {cmd_mvu, cmd_csr};
            r_pwdata <= cmd_data;
            r_tgt    <= cmd_mvu;
            r_is_cmd <= is_command(cmd_csr);
            r_psel   <= 1'b1;
            r_pwrite <= 1'b1;
            r_pstrb  <= '1;
            r_state  <= SETUP;
          end
        end
        SETUP: begin
          r_penable <= 1'b1;
          r_state   <= ACCESS;
        end
        ACCESS: begin
          if (w_done || w_timeout) begin
            r_psel    <= 1'b0;
            r_penable <= 1'b0;
            r_pwrite  <= 1'b0;
            r_pstrb   <= '0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_err     <= 1'b0;
      r_err_mvu <= '0;
    end else if (w_fail
                 && (!r_err || err_clr)) begin
      r_err     <= 1'b1;
      r_err_mvu <= r_tgt;
    end else if (err_clr) begin
      r_err     <= 1'b0;
      r_err_mvu <= '0;
    end
  end

  mvu_busy_tracker u_busy (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_set  (w_set),
    .i_clr  (mvu_done),
    .o_busy (w_busy)
  );

  assign cmd_ready = w_accept;
  assign idle      = (r_state == IDLE)
                   & ~cmd_valid;
  assign paddr     = r_paddr;
  assign psel      = r_psel;
  assign penable   = r_penable;
  assign pwrite    = r_pwrite;
  assign pwdata    = r_pwdata;
  assign pstrb     = r_pstrb;
  assign mvu_busy  = w_busy;
  assign err       = r_err;
  assign err_mvu   = r_err_mvu;

endmodule

// File: tb/tb_mvu_csr_sequencer.sv
// tb_mvu_csr_sequencer: directed scenarios plus a randomized run
// checked against a descriptor-queue reference model.
module tb_mvu_csr_sequencer;

   typedef struct {
      logic [2:0]  mvu;
      logic [11:0] csr;
      logic [31:0] data;
   } desc_t;

   localparam int NRAND = 150;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cmd_valid;
   logic        cmd_ready;
   logic [2:0]  cmd_mvu;
   logic [11:0] cmd_csr;
   logic [31:0] cmd_data;
   logic [14:0] paddr;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [31:0] pwdata;
   logic [3:0]  pstrb;
   logic        pready;
   logic        pslverr;
   logic [7:0]  mvu_done;
   logic [7:0]  mvu_busy;
   logic        idle;
   logic        err;
   logic [2:0]  err_mvu;
   logic        err_clr;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mvu_csr_sequencer #(.TIMEOUT_CYCLES(8)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_mvu   (cmd_mvu),
      .cmd_csr   (cmd_csr),
      .cmd_data  (cmd_data),
      .paddr     (paddr),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .pwdata    (pwdata),
      .pstrb     (pstrb),
      .pready    (pready),
      .pslverr   (pslverr),
      .mvu_done  (mvu_done),
      .mvu_busy  (mvu_busy),
      .idle      (idle),
      .err       (err),
      .err_mvu   (err_mvu),
      .err_clr   (err_clr)
   );

   task automatic issue(input logic [2:0] m, input logic [11:0] c,
                        input logic [31:0] d, output int waited);
      bit got;
      got = 0;
      waited = 0;
      cmd_valid = 1'b1;
      cmd_mvu = m;
      cmd_csr = c;
      cmd_data = d;
      for (int i = 0; i < 50; i++) begin
         #1;
         if (cmd_ready === 1'b1) begin
            got = 1;
            break;
         end
         @(negedge clk);
         waited++;
      end
      checks++;
      if (!got) begin
         errors++;
         $display("FAIL issue_accept: mvu=%0d csr=%h never accepted", m, c);
      end
      @(posedge clk);
      @(negedge clk);
      cmd_valid = 1'b0;
   endtask

   task automatic pulse_err_clr();
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      cmd_valid = 1'b0;
      cmd_mvu = '0;
      cmd_csr = '0;
      cmd_data = '0;
      pready = 1'b1;
      pslverr = 1'b0;
      mvu_done = '0;
      err_clr = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if ({psel, penable, pwrite, cmd_ready, err} !== 5'b0 ||
          pstrb !== 4'h0 || paddr !== 15'h0 || pwdata !== 32'h0 ||
          mvu_busy !== 8'h0 || err_mvu !== 3'h0 || idle !== 1'b1) begin
         errors++;
         $display("FAIL reset: psel=%b pen=%b pwr=%b rdy=%b err=%b strb=%h addr=%h busy=%h idle=%b, required all 0 and idle=1",
                  psel, penable, pwrite, cmd_ready, err, pstrb, paddr,
                  mvu_busy, idle);
      end
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_write();
      int w;
      issue(3'd3, 12'hf20, 32'h10, w);
      checks++;
      if (w != 0) begin
         errors++;
         $display("FAIL single_wait: waited %0d, required 0", w);
      end
      checks++;
      if (psel !== 1'b1 || penable !== 1'b0 || pwrite !== 1'b1 ||
          pstrb !== 4'hf || paddr !== 15'h3f20 || pwdata !== 32'h10) begin
         errors++;
         $display("FAIL single_setup: psel=%b pen=%b pwr=%b strb=%h addr=%h data=%h, required 1 0 1 f 3f20 10",
                  psel, penable, pwrite, pstrb, paddr, pwdata);
      end
      @(negedge clk);
      checks++;
      if (psel !== 1'b1 || penable !== 1'b1 || paddr !== 15'h3f20) begin
         errors++;
         $display("FAIL single_access: psel=%b pen=%b addr=%h, required 1 1 3f20",
                  psel, penable, paddr);
      end
      @(negedge clk);
      checks++;
      if (psel !== 1'b0 || penable !== 1'b0 || mvu_busy !== 8'h00 ||
          idle !== 1'b1) begin
         errors++;
         $display("FAIL single_done: psel=%b pen=%b busy=%h idle=%b, required 0 0 00 1",
                  psel, penable, mvu_busy, idle);
      end
   endtask

   task automatic test_command_busy();
      int w;
      bit leak;
      leak = 0;
      issue(3'd2, 12'hf55, 32'h1, w);
      repeat (2) @(negedge clk);
      checks++;
      if (mvu_busy !== 8'h04) begin
         errors++;
         $display("FAIL busy_set: busy=%h, required 04", mvu_busy);
      end
      cmd_valid = 1'b1;
      cmd_mvu = 3'd2;
      cmd_csr = 12'hf20;
      cmd_data = 32'h7;
      for (int i = 0; i < 4; i++) begin
         #1;
         if (cmd_ready !== 1'b0 || psel !== 1'b0) leak = 1;
         @(negedge clk);
      end
      checks++;
      if (leak) begin
         errors++;
         $display("FAIL busy_gate: write to busy MVU 2 was accepted, required stall");
      end
      mvu_done = 8'h04;
      #1;
      checks++;
      if (cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL busy_done_cycle: ready=%b, required 0", cmd_ready);
      end
      @(negedge clk);
      mvu_done = 8'h00;
      #1;
      checks++;
      if (mvu_busy !== 8'h00 || cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL busy_release: busy=%h ready=%b, required 00 1",
                  mvu_busy, cmd_ready);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++;
      if (psel !== 1'b1 || paddr !== 15'h2f20 || pwdata !== 32'h7) begin
         errors++;
         $display("FAIL busy_issue: psel=%b addr=%h data=%h, required 1 2f20 7",
                  psel, paddr, pwdata);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_head_of_line();
      int w;
      bit leak;
      leak = 0;
      issue(3'd2, 12'hf55, 32'h1, w);
      repeat (2) @(negedge clk);
      cmd_valid = 1'b1;
      cmd_mvu = 3'd2;
      cmd_csr = 12'hf10;
      cmd_data = 32'haa;
      for (int i = 0; i < 3; i++) begin
         #1;
         if (cmd_ready !== 1'b0 || psel !== 1'b0) leak = 1;
         @(negedge clk);
      end
      checks++;
      if (leak) begin
         errors++;
         $display("FAIL hol_stall: head to busy MVU issued, required stall");
      end
      mvu_done = 8'h04;
      @(negedge clk);
      mvu_done = 8'h00;
      @(posedge clk);
      @(negedge clk);
      cmd_mvu = 3'd5;
      cmd_csr = 12'hf11;
      cmd_data = 32'hbb;
      #1;
      checks++;
      if (psel !== 1'b1 || paddr !== 15'h2f10 || pwdata !== 32'haa ||
          cmd_ready !== 1'b0) begin
         errors++;
         $display("FAIL hol_first: psel=%b addr=%h data=%h rdy=%b, required 1 2f10 aa 0",
                  psel, paddr, pwdata, cmd_ready);
      end
      @(negedge clk);
      @(negedge clk);
      #1;
      checks++;
      if (cmd_ready !== 1'b1) begin
         errors++;
         $display("FAIL hol_second_ready: rdy=%b, required 1", cmd_ready);
      end
      @(negedge clk);
      cmd_valid = 1'b0;
      checks++;
      if (psel !== 1'b1 || paddr !== 15'h5f11 || pwdata !== 32'hbb) begin
         errors++;
         $display("FAIL hol_second: psel=%b addr=%h data=%h, required 1 5f11 bb",
                  psel, paddr, pwdata);
      end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_wait_states();
      int w;
      bit stable;
      stable = 1;
      pready = 1'b0;
      issue(3'd1, 12'hf30, 32'h55, w);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         if (psel !== 1'b1 || penable !== 1'b1 ||
             paddr !== 15'h1f30 || pwdata !== 32'h55) stable = 0;
         if (i == 4) pready = 1'b1;
      end
      checks++;
      if (!stable) begin
         errors++;
         $display("FAIL wait_stable: APB signals moved during 5 ACCESS cycles");
      end
      @(negedge clk);
      checks++;
      if (psel !== 1'b0 || penable !== 1'b0) begin
         errors++;
         $display("FAIL wait_complete: psel=%b pen=%b, required 0 0",
                  psel, penable);
      end
   endtask

   task automatic test_slverr();
      int w;
      pslverr = 1'b1;
      issue(3'd6, 12'hf55, 32'h1, w);
      repeat (2) @(negedge clk);
      checks++;
      if (err !== 1'b1 || err_mvu !== 3'd6 || mvu_busy[6] !== 1'b0) begin
         errors++;
         $display("FAIL slverr_first: err=%b mvu=%0d busy6=%b, required 1 6 0",
                  err, err_mvu, mvu_busy[6]);
      end
      issue(3'd1, 12'hf20, 32'h0, w);
      repeat (2) @(negedge clk);
      checks++;
      if (err !== 1'b1 || err_mvu !== 3'd6) begin
         errors++;
         $display("FAIL slverr_sticky: err=%b mvu=%0d, required 1 6",
                  err, err_mvu);
      end
      pslverr = 1'b0;
      pulse_err_clr();
      checks++;
      if (err !== 1'b0 || err_mvu !== 3'd0) begin
         errors++;
         $display("FAIL slverr_clear: err=%b mvu=%0d, required 0 0",
                  err, err_mvu);
      end
      pslverr = 1'b1;
      issue(3'd6, 12'hf20, 32'h3, w);
      repeat (2) @(negedge clk);
      issue(3'd4, 12'hf55, 32'h1, w);
      @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      pslverr = 1'b0;
      checks++;
      if (err !== 1'b1 || err_mvu !== 3'd4 || mvu_busy[4] !== 1'b0) begin
         errors++;
         $display("FAIL slverr_vs_clr: err=%b mvu=%0d busy4=%b, required 1 4 0",
                  err, err_mvu, mvu_busy[4]);
      end
      pulse_err_clr();
   endtask

   task automatic test_busy_edges();
      int w;
      mvu_done = 8'h80;
      @(negedge clk);
      mvu_done = 8'h00;
      checks++;
      if (mvu_busy !== 8'h00) begin
         errors++;
         $display("FAIL done_idle_mvu: busy=%h, required 00", mvu_busy);
      end
      issue(3'd7, 12'hf55, 32'h1, w);
      @(negedge clk);
      mvu_done = 8'h80;
      @(negedge clk);
      mvu_done = 8'h00;
      checks++;
      if (mvu_busy !== 8'h80) begin
         errors++;
         $display("FAIL set_beats_clear: busy=%h, required 80", mvu_busy);
      end
      mvu_done = 8'h80;
      @(negedge clk);
      mvu_done = 8'h00;
      checks++;
      if (mvu_busy !== 8'h00) begin
         errors++;
         $display("FAIL busy_clear: busy=%h, required 00", mvu_busy);
      end
   endtask

`ifdef MVU_CSR_SEQ_TIMEOUT_EN
   task automatic test_timeout();
      int w;
      bit held;
      held = 1;
      pready = 1'b0;
      issue(3'd4, 12'hf55, 32'h1, w);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (psel !== 1'b1 || penable !== 1'b1) held = 0;
      end
      checks++;
      if (!held) begin
         errors++;
         $display("FAIL timeout_hold: transfer dropped before 8 ACCESS cycles");
      end
      @(negedge clk);
      checks++;
      if (psel !== 1'b0 || penable !== 1'b0 || err !== 1'b1 ||
          err_mvu !== 3'd4 || mvu_busy !== 8'h00 || idle !== 1'b1) begin
         errors++;
         $display("FAIL timeout_abort: psel=%b pen=%b err=%b mvu=%0d busy=%h idle=%b, required 0 0 1 4 00 1",
                  psel, penable, err, err_mvu, mvu_busy, idle);
      end
      pready = 1'b1;
      pulse_err_clr();
   endtask
`endif

   task automatic test_reset_mid();
      int w;
      pready = 1'b1;
      issue(3'd5, 12'hf55, 32'h1, w);
      @(negedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checks++;
      if (psel !== 1'b0 || penable !== 1'b0) begin
         errors++;
         $display("FAIL reset_async: psel=%b pen=%b, required 0 0",
                  psel, penable);
      end
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      checks++;
      if (mvu_busy !== 8'h00 || idle !== 1'b1) begin
         errors++;
         $display("FAIL reset_no_busy: busy=%h idle=%b, required 00 1",
                  mvu_busy, idle);
      end
   endtask

   task automatic test_random();
      desc_t      q[$];
      desc_t      nd;
      desc_t      hd;
      bit         have;
      bit         fin;
      bit         fail;
      bit         exp_rdy;
      int         sent;
      int         lowrun;
      logic [7:0] m_busy;
      logic [7:0] setm;
      logic       m_err;
      logic [2:0] m_emvu;
      logic [2:0] fm;
      have = 0;
      fin = 0;
      sent = 0;
      lowrun = 0;
      m_busy = '0;
      m_err = 1'b0;
      m_emvu = '0;
      for (int cyc = 0; cyc < 5000; cyc++) begin
         @(negedge clk);
         checks++;
         if (mvu_busy !== m_busy || err !== m_err || err_mvu !== m_emvu) begin
            errors++;
            $display("FAIL rnd_state: cyc=%0d busy=%h err=%b mvu=%0d, required %h %b %0d",
                     cyc, mvu_busy, err, err_mvu, m_busy, m_err, m_emvu);
         end
         if (sent == NRAND && q.size() == 0 && psel === 1'b0) begin
            fin = 1;
            break;
         end
         if (!have && sent < NRAND) begin
            nd.mvu = 3'($urandom_range(0, 7));
            nd.csr = ($urandom_range(0, 2) == 0) ? 12'hf55
                   : 12'(12'hf20 + $urandom_range(0, 15));
            nd.data = $urandom;
            have = 1;
         end
         cmd_valid = have;
         cmd_mvu = nd.mvu;
         cmd_csr = nd.csr;
         cmd_data = nd.data;
         pready = (lowrun >= 3) ? 1'b1 : ($urandom_range(0, 2) != 0);
         lowrun = pready ? 0 : lowrun + 1;
         pslverr = ($urandom_range(0, 7) == 0);
         for (int i = 0; i < 8; i++)
            mvu_done[i] = ($urandom_range(0, 4) == 0);
         err_clr = ($urandom_range(0, 11) == 0);
         #1;
         exp_rdy = have && !psel && !m_busy[nd.mvu];
         checks++;
         if (cmd_ready !== exp_rdy) begin
            errors++;
            $display("FAIL rnd_ready: cyc=%0d rdy=%b, required %b",
                     cyc, cmd_ready, exp_rdy);
         end
         if (psel === 1'b1) begin
            checks++;
            if (q.size() == 0) begin
               errors++;
               $display("FAIL rnd_xfer: cyc=%0d addr=%h with no accepted descriptor",
                        cyc, paddr);
            end else if (paddr !== {q[0].mvu, q[0].csr} ||
                         pwdata !== q[0].data || pwrite !== 1'b1 ||
                         pstrb !== 4'hf) begin
               errors++;
               $display("FAIL rnd_xfer: cyc=%0d addr=%h data=%h, required %h %h",
                        cyc, paddr, pwdata, {q[0].mvu, q[0].csr}, q[0].data);
            end
         end
         setm = '0;
         fail = 0;
         fm = '0;
         if (psel === 1'b1 && penable === 1'b1 && pready && q.size() > 0) begin
            hd = q.pop_front();
            if (pslverr) begin
               fail = 1;
               fm = hd.mvu;
            end else if (hd.csr == 12'hf55) begin
               setm[hd.mvu] = 1'b1;
            end
         end
         if (cmd_valid && cmd_ready === 1'b1) begin
            q.push_back(nd);
            have = 0;
            sent++;
         end
         m_busy = (m_busy & ~mvu_done) | setm;
         if (fail && (!m_err || err_clr)) begin
            m_err = 1'b1;
            m_emvu = fm;
         end else if (err_clr) begin
            m_err = 1'b0;
            m_emvu = '0;
         end
      end
      checks++;
      if (!fin) begin
         errors++;
         $display("FAIL rnd_drain: sent=%0d pending=%0d, required %0d 0",
                  sent, q.size(), NRAND);
      end
      cmd_valid = 1'b0;
      mvu_done = '0;
      err_clr = 1'b0;
      pslverr = 1'b0;
      pready = 1'b1;
   endtask

   initial begin
      test_reset();
      test_single_write();
      test_command_busy();
      test_head_of_line();
      test_wait_states();
      test_slverr();
      test_busy_edges();
`ifdef MVU_CSR_SEQ_TIMEOUT_EN
      test_timeout();
`endif
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1);
   end

endmodule

// File: doc/mvu_csr_sequencer.md
Name: mvu_csr_sequencer

Overview:
- APB master that turns a stream of CSR-write descriptors into APB write transfers into the 8-MVU CSR space.
- Tracks a per-MVU busy flag: set when CSR_MVUCOMMAND is written, cleared on that MVU's done pulse.
- Holds back any descriptor aimed at a busy MVU, so a running job's configuration is never overwritten.
- Sits between the host/descriptor queue and the MVU array's APB slave port.

Parameters:
- NMVU, 8, number of MVUs; MVU select width MVUW = $clog2(NMVU).
- APB_ADDR_WIDTH, 15, APB address width = MVUW + 12.
- APB_DATA_WIDTH, 32, APB data width.
- TIMEOUT_CYCLES, 256, maximum ACCESS-phase wait (optional feature only).

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  descriptor valid
- cmd_ready  out  1  descriptor accepted when valid & ready
- cmd_mvu  in  MVUW  target MVU index
- cmd_csr  in  12  CSR address (mvu_csr_t)
- cmd_data  in  APB_DATA_WIDTH  write data
- paddr  out  APB_ADDR_WIDTH  {mvu, csr}
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  always 1 during a transfer
- pwdata  out  APB_DATA_WIDTH  write data
- pstrb  out  APB_DATA_WIDTH/8  all ones during a transfer
- pready  in  1  slave ready
- pslverr  in  1  slave error
- mvu_done  in  NMVU  one-cycle job-done pulse per MVU
- mvu_busy  out  NMVU  per-MVU job-in-flight flag
- idle  out  1  FSM in IDLE and cmd_valid low
- err  out  1  sticky error
- err_mvu  out  MVUW  MVU of first error
- err_clr  in  1  clears err and err_mvu

Behaviour:
- Reset (async, rst_n=0):
  - State IDLE.
  - psel, penable, pwrite, pstrb, paddr, pwdata, mvu_busy, err, err_mvu all 0; cmd_ready=0.
  - Reset mid-transfer aborts immediately; no busy flag is set.
- FSM states: IDLE, SETUP, ACCESS.
- IDLE:
  - cmd_ready = cmd_valid & ~mvu_busy[cmd_mvu] (combinational on the head descriptor).
  - On accept: latch paddr={cmd_mvu,cmd_csr}, pwdata, target MVU and is_cmd=(cmd_csr==12'hf55); go to SETUP.
- SETUP: psel=1, penable=0, pwrite=1, pstrb all ones; always go to ACCESS next cycle.
- ACCESS:
  - psel=1, penable=1; wait for pready.
  - On pready=1: drop psel/penable in the next cycle and return to IDLE.
  - If pslverr=0 and is_cmd: set mvu_busy[target].
  - If pslverr=1: no busy set; if err=0, set err and err_mvu=target.
- Throughput: one write per 3 cycles minimum (accept, SETUP, ACCESS with pready=1); there are no back-to-back accepts.
- Head-of-line blocking: a descriptor to a busy MVU stalls the stream; later descriptors to idle MVUs also wait.
- Busy clear: mvu_done[i]=1 clears mvu_busy[i] next edge.
  - If a set and a clear hit the same MVU in the same cycle, set wins.
  - mvu_done for a non-busy MVU is ignored.
- Busy gates every CSR write to that MVU, not only COMMAND.
- err_clr and a new error in the same cycle: error wins, err stays 1, err_mvu takes the new value.
- paddr/pwdata hold stable from SETUP through ACCESS completion; values in IDLE are don't-care but hold their last value.

Optional Feature:
- Macro: MVU_CSR_SEQ_TIMEOUT_EN.
- Defined: an ACCESS-cycle counter of $clog2(TIMEOUT_CYCLES)+1 bits.
  - If pready has not been seen after TIMEOUT_CYCLES ACCESS cycles, the transfer is abandoned: psel/penable drop, return to IDLE, err set (first-error rules apply), no busy set.
  - Counter clears on entry to SETUP.
- Undefined: no counter; ACCESS waits on pready indefinitely.

Decomposition:
- Shared package mvu_pkg provides:
  - NMVU, APB_ADDR_WIDTH, APB_DATA_WIDTH, APB_STRB_WIDTH, apb_addr_t, apb_data_t, apb_strb_t.
  - mvu_csr_t with CSR_MVUCOMMAND.
  - New: seq_state_t enum {IDLE,SETUP,ACCESS}, and typedef mvu_sel_t = logic[$clog2(NMVU)-1:0].
- One natural sub-module, mvu_busy_tracker: NMVU set/clear flag array with set-priority.

Test Plan:
- Single write mvu=3, csr=f20, data=0x10, pready=1 -> paddr=0x3f20, psel 1 for 2 cycles, penable 1 only in cycle 2, mvu_busy unchanged.
- Write mvu=2, csr=f55, data=1 -> mvu_busy=8'h04; next descriptor to mvu=2 sees cmd_ready=0 until mvu_done[2] pulses, then it is accepted the following cycle.
- Busy on MVU 2, head descriptor to MVU 2, next descriptor to MVU 5 -> neither issued (head-of-line); after mvu_done[2] both issue in order.
- pready held low 4 cycles -> psel/penable/paddr stable for 5 ACCESS cycles, completion on the 5th.
- COMMAND to mvu=6 with pslverr=1 -> err=1, err_mvu=6, mvu_busy[6]=0; err_clr -> err=0.
- With MVU_CSR_SEQ_TIMEOUT_EN defined and TIMEOUT_CYCLES=8, pready held low -> psel drops after 8 ACCESS cycles, err=1, FSM back in IDLE with idle=1.
